w_bank_loader: RTL and testbench
================================

# w_bank_loader

Parametrised weight scatter engine for the scheduler. It copies a row-major weight matrix of runtime-selected size from the flat weight BRAM into per-column banks, and it serves every column bank in parallel to the multiplier array. The banks are organised as `NUM_SETS` independent bank sets, so the next layer's weights can load while the current set is being read. It replaces the single-shot, fixed-size column loader and adds runtime dimensions, a source base address, a configurable source read latency, reload and per-set valid tracking.

## Interface
- `DATA_WIDTH`, default 8: weight element width.
- `MAX_ROWS`, default 16: bank depth, i.e. the largest supported row count.
- `MAX_COLS`, default 16: number of column banks per set.
- `NUM_SETS`, default 2: number of independent bank sets.
- `SRC_ADDR_W`, default 12: weight BRAM address width.
- `RD_LATENCY`, default 1: weight BRAM read latency in cycles, legal range 1..3.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid_i` in 1: load request.
- `load_ready_o` out 1: high only in IDLE.
- `cfg_rows_i` in clog2(MAX_ROWS+1): row count R.
- `cfg_cols_i` in clog2(MAX_COLS+1): column count C.
- `cfg_base_i` in SRC_ADDR_W: source address of element (0,0).
- `cfg_set_i` in clog2(NUM_SETS): destination bank set.
- `busy_o` out 1: high in ISSUE, DRAIN and DONE.
- `done_o` out 1: one-cycle pulse when a load completes.
- `err_o` out 1: one-cycle pulse when a request is rejected.
- `set_valid_o` out NUM_SETS: set holds a complete matrix.
- `src_en_o` out 1: weight BRAM read enable.
- `src_addr_o` out SRC_ADDR_W: weight BRAM read address.
- `src_dout_i` in DATA_WIDTH: weight BRAM read data.
- `rd_set_i` in clog2(NUM_SETS): read-side set select.
- `rd_addr_i` in MAX_COLS×clog2(MAX_ROWS): per-bank row address.
- `rd_dout_o` out MAX_COLS×DATA_WIDTH: per-bank data, combinational from `rd_set_i` and `rd_addr_i`.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE, accept condition:** a handshake occurs when `load_valid_i && load_ready_o`.
  - The config is legal when 1≤R≤MAX_ROWS, 1≤C≤MAX_COLS and `cfg_set_i`<NUM_SETS.
  - Legal config: latch R, C, base and set; clear `set_valid_o[set]` on the same edge; go to ISSUE.
  - Illegal config: pulse `err_o` for one cycle, stay in IDLE, leave all sets untouched.
- **ISSUE:**
  - Assert `src_en_o` every cycle, with address base+k for k=0..R·C−1.
  - Row counter r and column counter c step column-first: c wraps at C−1 and r then increments.
  - Each issued read pushes a tag {valid, r, c} into a RD_LATENCY-deep shift register.
  - After the read with k=R·C−1, go to DRAIN.
- **Write side:** when a tag exits the shift register, write `src_dout_i` into bank c of the latched set at address r. Only that bank is enabled.
- **DRAIN:** stay RD_LATENCY cycles until the tag pipe is empty, then go to DONE.
- **DONE:** one cycle. Assert `done_o` and set `set_valid_o[set]` on the exit edge, then return to IDLE.
- **Address arithmetic:** `src_addr_o` is a running incrementer, not a multiply. base+k wraps modulo 2^SRC_ADDR_W.
- **Partial sizes:** bank entries with row ≥R, and banks with index ≥C, keep their old contents.
- **Read side:** always enabled. Reading the set currently being loaded returns mixed old and new data; `set_valid_o` low flags this condition.
- **Requests while busy:** `load_valid_i` is ignored outside IDLE.
- **Reset:** asserting `rst_n` at any point, including mid-load, immediately forces IDLE and clears all `set_valid_o`, the tag pipe and the counters. Bank contents are not cleared.

## Timing
- Cycle 0 is the accept edge. Let N=R·C and L=RD_LATENCY.
- ISSUE occupies cycles 1..N, with `src_addr_o`=base+(t−1) in cycle t.
- Data issued in cycle t is sampled in cycle t+L and written on that cycle's closing edge. The last write is in cycle N+L.
- DRAIN occupies cycles N+1..N+L.
- DONE is cycle N+L+1, with `done_o`=1 in that cycle. `set_valid_o[set]`=1 and `load_ready_o`=1 from cycle N+L+2.
- Rejected request: `err_o` is high in the cycle after the handshake, and `load_ready_o` stays high throughout.
- Reset values:
  - `load_ready_o`=1.
  - `busy_o`, `done_o`, `err_o`, `src_en_o`=0.
  - `src_addr_o`=0.
  - `set_valid_o`=0.
  - `rd_dout_o` reflects the current bank contents.

## Structure
- Add to `params_pkg`:
  - the FSM state enum `wbl_state_e`;
  - the tag struct `wbl_tag_t` {valid, row, col};
  - the derived widths `WBL_ROW_W`, `WBL_COL_W` and `WBL_SET_W`.
- Reuse the existing `BRAM` module with CLK_LATENCY 0, instantiating NUM_SETS×MAX_COLS copies, each of depth MAX_ROWS.
- The read mux over sets is a generate loop. No new sub-module.

## Test plan
- **Full load:** R=4, C=3, base=0x10, set 0, source holds mem[a]=a, L=1.
  - Bank c addr r must read 0x10+3r+c.
  - `done_o` must pulse in cycle 14.
- **Latency sweep:** L=3, R=2, C=2.
  - `done_o` must pulse in cycle 8.
  - Data must match with no off-by-one in any bank.
- **Double buffer:** load set 0, then start a set-1 load while reading set 0.
  - Set-0 data must stay stable.
  - `set_valid_o` must read 01 during the set-1 load and 11 after.
- **Illegal config:** C=0, or R=MAX_ROWS+1.
  - `err_o` must pulse once.
  - There must be no `src_en_o` activity and no change to `set_valid_o`.
- **Mid-load reset:** R=4, C=4, with `rst_n` low in cycle 7.
  - Outputs must return to reset values asynchronously.
  - A fresh load must then complete correctly.
- **Address wrap:** SRC_ADDR_W=4, base=14, R=1, C=4.
  - Addresses must be 14, 15, 0, 1.

Source files
------------

// File: rtl/w_bank_loader_pkg.sv
// w_bank_loader_pkg: shared types, tag field widths and width helper for the weight bank loader
package w_bank_loader_pkg;

    // Tag field capacities; they bound the largest MAX_ROWS / MAX_COLS / NUM_SETS the loader supports
    localparam int WBL_ROW_W = 16;
    localparam int WBL_COL_W = 16;
    localparam int WBL_SET_W = 8;

    typedef enum logic [1:0] {
        WBL_IDLE,
        WBL_ISSUE,
        WBL_DRAIN,
        WBL_DONE
    } wbl_state_e;

    typedef struct packed {
        logic                 valid;
        logic [WBL_ROW_W-1:0] row;
        logic [WBL_COL_W-1:0] col;
    } wbl_tag_t;

    // Index width for n entries, never narrower than one bit
    function automatic int wbl_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/w_bank_loader_bram.sv
// BRAM: simple dual-port memory, one write port and one read port with 0..N cycles of read latency
module BRAM #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int CLK_LATENCY = 0,
    parameter int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    generate
        if (CLK_LATENCY == 0) begin : g_comb
            assign rdata_o = mem_q[raddr_i];
        end else begin : g_pipe
            logic [DATA_WIDTH-1:0] pipe_q [CLK_LATENCY];
            // Read pipeline delaying the array output by CLK_LATENCY cycles
            always_ff @(posedge clk) begin
                pipe_q[0] <= mem_q[raddr_i];
                for (int i = 1; i < CLK_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end
            assign rdata_o = pipe_q[CLK_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/w_bank_loader.sv
// w_bank_loader: scatters a row-major weight matrix from the weight BRAM into double-buffered column banks
module w_bank_loader
    import w_bank_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_ROWS   = 16,
    parameter int MAX_COLS   = 16,
    parameter int NUM_SETS   = 2,
    parameter int SRC_ADDR_W = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   load_valid_i,
    output logic                                   load_ready_o,
    input  logic [$clog2(MAX_ROWS+1)-1:0]          cfg_rows_i,
    input  logic [$clog2(MAX_COLS+1)-1:0]          cfg_cols_i,
    input  logic [SRC_ADDR_W-1:0]                  cfg_base_i,
    input  logic [wbl_w(NUM_SETS)-1:0]             cfg_set_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o,
    output logic [NUM_SETS-1:0]                    set_valid_o,
    output logic                                   src_en_o,
    output logic [SRC_ADDR_W-1:0]                  src_addr_o,
    input  logic [DATA_WIDTH-1:0]                  src_dout_i,
    input  logic [wbl_w(NUM_SETS)-1:0]             rd_set_i,
    input  logic [MAX_COLS*wbl_w(MAX_ROWS)-1:0]    rd_addr_i,
    output logic [MAX_COLS*DATA_WIDTH-1:0]         rd_dout_o
);

    localparam int RW  = wbl_w(MAX_ROWS);
    localparam int SW  = wbl_w(NUM_SETS);
    localparam int CRW = $clog2(MAX_ROWS+1);
    localparam int CCW = $clog2(MAX_COLS+1);

    wbl_state_e            state_q;
    logic [CRW-1:0]        rows_q, r_q;
    logic [CCW-1:0]        cols_q, c_q;
    logic [SRC_ADDR_W-1:0] addr_q;
    logic [SW-1:0]         set_q;
    logic [1:0]            dc_q;
    logic [NUM_SETS-1:0]   sv_q;
    logic                  err_q;
    wbl_tag_t              tag_q [RD_LATENCY];
    wbl_tag_t              tag_d, wr_tag;
    logic                  cfg_ok, last_k, col_wrap;
    logic [DATA_WIDTH-1:0] bank_dout [NUM_SETS][MAX_COLS];

    assign cfg_ok = (cfg_rows_i != '0) && (cfg_rows_i <= CRW'(MAX_ROWS))
                 && (cfg_cols_i != '0) && (cfg_cols_i <= CCW'(MAX_COLS))
                 && ({1'b0, cfg_set_i} < (SW+1)'(NUM_SETS));
    assign col_wrap = (c_q == cols_q - 1'b1);
    assign last_k   = col_wrap && (r_q == rows_q - 1'b1);

    // Control FSM: accepts/rejects requests, walks the matrix column-first, drains the read pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WBL_IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            addr_q  <= '0;
            set_q   <= '0;
            dc_q    <= '0;
            sv_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                WBL_IDLE: begin
                    if (load_valid_i && cfg_ok) begin
                        rows_q           <= cfg_rows_i;
                        cols_q           <= cfg_cols_i;
                        addr_q           <= cfg_base_i;
                        set_q            <= cfg_set_i;
                        r_q              <= '0;
                        c_q              <= '0;
                        sv_q[cfg_set_i]  <= 1'b0;
                        state_q          <= WBL_ISSUE;
                    end else if (load_valid_i) begin
                        err_q <= 1'b1;
                    end
                end
                WBL_ISSUE: begin
                    addr_q <= addr_q + 1'b1;
                    c_q    <= col_wrap ? '0 : c_q + 1'b1;
                    r_q    <= col_wrap ? r_q + 1'b1 : r_q;
                    if (last_k) begin
                        dc_q    <= '0;
                        state_q <= WBL_DRAIN;
                    end
                end
                WBL_DRAIN: begin
                    dc_q <= dc_q + 1'b1;
                    if (dc_q == 2'(RD_LATENCY-1)) state_q <= WBL_DONE;
                end
                WBL_DONE: begin
                    sv_q[set_q] <= 1'b1;
                    state_q     <= WBL_IDLE;
                end
                default: state_q <= WBL_IDLE;
            endcase
        end
    end

    assign tag_d = '{valid: (state_q == WBL_ISSUE), row: WBL_ROW_W'(r_q), col: WBL_COL_W'(c_q)};
    assign wr_tag = tag_q[RD_LATENCY-1];

    // Tag pipe matching the source read latency, so each returning word knows its (row, col)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    genvar s, c;
    generate
        for (s = 0; s < NUM_SETS; s++) begin : g_set
            for (c = 0; c < MAX_COLS; c++) begin : g_col
                BRAM #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .DEPTH      (MAX_ROWS),
                    .CLK_LATENCY(0),
                    .ADDR_W     (RW)
                ) u_bank (
                    .clk    (clk),
                    .we_i   (wr_tag.valid && (wr_tag.col == WBL_COL_W'(c)) && (set_q == SW'(s))
                             && (wr_tag.row < WBL_ROW_W'(MAX_ROWS))),
                    .waddr_i(wr_tag.row[RW-1:0]),
                    .wdata_i(src_dout_i),
                    .raddr_i(rd_addr_i[c*RW +: RW]),
                    .rdata_o(bank_dout[s][c])
                );
            end
        end
        for (c = 0; c < MAX_COLS; c++) begin : g_rd
            assign rd_dout_o[c*DATA_WIDTH +: DATA_WIDTH] = bank_dout[rd_set_i][c];
        end
    endgenerate

    assign load_ready_o = (state_q == WBL_IDLE);
    assign busy_o       = (state_q != WBL_IDLE);
    assign done_o       = (state_q == WBL_DONE);
    assign err_o        = err_q;
    assign set_valid_o  = sv_q;
    assign src_en_o     = (state_q == WBL_ISSUE);
    assign src_addr_o   = addr_q;

endmodule

// File: tb/tb_w_bank_loader.sv
// tb_w_bank_loader: table-driven loads on latency-1 and latency-3 instances plus reset corner cases
module tb_w_bank_loader;

    typedef struct {
        int dut;
        int r;
        int c;
        int base;
        int set;
        int err;
        int done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        lv1 = 1'b0, lv3 = 1'b0;
    logic [4:0]  rows = '0, cols = '0;
    logic [11:0] base = '0;
    logic        set = 1'b0;
    logic        rd_set = 1'b0;
    logic [63:0] rd_addr = '0;
    logic        sel = 1'b0;

    logic        ready1, busy1, done1, err1, en1;
    logic        ready3, busy3, done3, err3, en3;
    logic [1:0]  sv1, sv3;
    logic [11:0] addr1, addr3;
    logic [127:0] rd1, rd3;
    logic [7:0]  s1_q;
    logic [7:0]  s3_q [3];

    w_bank_loader #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid_i(lv1), .load_ready_o(ready1),
        .cfg_rows_i(rows), .cfg_cols_i(cols), .cfg_base_i(base), .cfg_set_i(set),
        .busy_o(busy1), .done_o(done1), .err_o(err1), .set_valid_o(sv1),
        .src_en_o(en1), .src_addr_o(addr1), .src_dout_i(s1_q),
        .rd_set_i(rd_set), .rd_addr_i(rd_addr), .rd_dout_o(rd1)
    );

    w_bank_loader #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .load_valid_i(lv3), .load_ready_o(ready3),
        .cfg_rows_i(rows), .cfg_cols_i(cols), .cfg_base_i(base), .cfg_set_i(set),
        .busy_o(busy3), .done_o(done3), .err_o(err3), .set_valid_o(sv3),
        .src_en_o(en3), .src_addr_o(addr3), .src_dout_i(s3_q[2]),
        .rd_set_i(rd_set), .rd_addr_i(rd_addr), .rd_dout_o(rd3)
    );

    // Source BRAM models: mem[a] = a[7:0], returned after 1 and 3 cycles
    always @(posedge clk) begin
        s1_q    <= addr1[7:0];
        s3_q[0] <= addr3[7:0];
        s3_q[1] <= s3_q[0];
        s3_q[2] <= s3_q[1];
    end

    logic         ready_s, done_s, err_s, en_s;
    logic [1:0]   sv_s;
    logic [11:0]  addr_s;
    logic [127:0] rd_s;
    assign ready_s = sel ? ready3 : ready1;
    assign done_s  = sel ? done3  : done1;
    assign err_s   = sel ? err3   : err1;
    assign en_s    = sel ? en3    : en1;
    assign sv_s    = sel ? sv3    : sv1;
    assign addr_s  = sel ? addr3  : addr1;
    assign rd_s    = sel ? rd3    : rd1;

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [2][2][16][16];
    bit         kn  [2][2][16][16];
    logic [1:0] msv [2];
    vec_t       vecs [9];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run_load(input vec_t v, input int id);
        int done_at = 0, errs = 0, ens = 0, abad = 0, svbad = 0, dbad = 0, rbad = 0, bad = 0;
        int d, o;
        logic [1:0]  sv_exp;
        logic [11:0] exp_addr;
        logic [3:0]  ra;
        d = v.dut;
        o = 1 - v.set;
        sel = (d == 1);
        sv_exp = msv[d];
        if (v.err == 0) sv_exp[v.set] = 1'b0;
        @(negedge clk);
        rows = 5'(v.r);
        cols = 5'(v.c);
        base = 12'(v.base);
        set  = 1'(v.set);
        if (d == 1) lv3 = 1'b1;
        else lv1 = 1'b1;
        @(posedge clk);
        #1 lv1 = 1'b0;
        lv3 = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (done_s && done_at == 0) done_at = t;
            if (err_s) errs++;
            if (en_s) begin
                exp_addr = 12'(v.base + ens);
                if (addr_s != exp_addr) abad++;
                ens++;
            end
            if (sv_s != sv_exp) svbad++;
            if (v.err != 0 && !ready_s) rbad++;
            ra = 4'(t);
            rd_set = 1'(o);
            rd_addr = {16{ra}};
            #1;
            for (int c = 0; c < 16; c++)
                if (kn[d][o][c][ra] && rd_s[c*8 +: 8] != mdl[d][o][c][ra]) dbad++;
            if ((v.err == 0 && done_at != 0) || (v.err != 0 && t == 6)) break;
        end
        check($sformatf("v%0d_err_pulses", id), errs, v.err);
        check($sformatf("v%0d_done_cycle", id), done_at, v.done);
        check($sformatf("v%0d_src_reads", id), ens, (v.err == 0) ? v.r * v.c : 0);
        check($sformatf("v%0d_src_addr_bad", id), abad, 0);
        check($sformatf("v%0d_set_valid_during_bad", id), svbad, 0);
        check($sformatf("v%0d_ready_drop_on_reject", id), rbad, 0);
        check($sformatf("v%0d_other_set_unstable", id), dbad, 0);
        if (v.err == 0) begin
            msv[d][v.set] = 1'b1;
            for (int r = 0; r < v.r; r++)
                for (int c = 0; c < v.c; c++) begin
                    mdl[d][v.set][c][r] = 8'(v.base + r * v.c + c);
                    kn[d][v.set][c][r]  = 1'b1;
                end
            @(negedge clk);
            check($sformatf("v%0d_set_valid_after", id), int'(sv_s), int'(msv[d]));
            check($sformatf("v%0d_ready_after", id), int'(ready_s), 1);
        end
        rd_set = 1'(v.set);
        for (int r = 0; r < 16; r++) begin
            ra = 4'(r);
            rd_addr = {16{ra}};
            #1;
            for (int c = 0; c < 16; c++)
                if (kn[d][v.set][c][r] && rd_s[c*8 +: 8] != mdl[d][v.set][c][r]) bad++;
        end
        check($sformatf("v%0d_bank_entries_bad", id), bad, 0);
    endtask

    initial begin
        msv[0] = '0;
        msv[1] = '0;
        //           dut  R   C   base    set err done
        vecs[0] = '{0,  4,  3, 'h010, 0, 0, 14};
        vecs[1] = '{0,  2,  2, 'h040, 1, 0, 6};
        vecs[2] = '{0,  4,  0, 'h080, 1, 1, 0};
        vecs[3] = '{0, 17,  1, 'h080, 0, 1, 0};
        vecs[4] = '{0, 16, 16, 'h100, 1, 0, 258};
        vecs[5] = '{0,  1,  4, 'hFFE, 1, 0, 6};
        vecs[6] = '{1,  2,  2, 'h030, 0, 0, 8};
        vecs[7] = '{1,  1,  1, 'h007, 1, 0, 5};
        vecs[8] = '{0,  4,  4, 'h200, 0, 0, 18};

        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready1), 1);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_err", int'(err1), 0);
        check("rst_src_en", int'(en1), 0);
        check("rst_src_addr", int'(addr1), 0);
        check("rst_set_valid", int'(sv1), 0);
        check("rst_set_valid3", int'(sv3), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_load(vecs[i], i);

        sel = 1'b0;
        @(negedge clk);
        rows = 5'd4;
        cols = 5'd4;
        base = 12'h200;
        set  = 1'b0;
        lv1  = 1'b1;
        @(posedge clk);
        #1 lv1 = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy_before", int'(busy1), 1);
        check("mid_src_en_before", int'(en1), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", int'(ready1), 1);
        check("mid_rst_busy", int'(busy1), 0);
        check("mid_rst_src_en", int'(en1), 0);
        check("mid_rst_src_addr", int'(addr1), 0);
        check("mid_rst_done", int'(done1), 0);
        check("mid_rst_err", int'(err1), 0);
        check("mid_rst_set_valid", int'(sv1), 0);
        check("mid_rst_set_valid3", int'(sv3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        msv[0] = '0;
        msv[1] = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) kn[0][0][c][r] = 1'b0;
        repeat (2) @(negedge clk);
        run_load(vecs[8], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
